display_scan_ctrl: RTL
======================

DISPLAY_SCAN_CTRL -- requirements
Module: display_scan_ctrl

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset, with clock port clk and reset port rst_n.
REQ-002 The block SHALL have parameter REFRESH_DIV, default 100000, giving clk cycles per digit slot (legal range ≥ 2).
REQ-003 The block SHALL have parameter BLANK_CYCLES, default 1000, giving guard cycles at the start of each slot (legal range 0 ≤ BLANK_CYCLES < REFRESH_DIV).
REQ-004 Port clk, input, 1 bit: system clock.
REQ-005 Port rst_n, input, 1 bit: asynchronous active-low reset.
REQ-006 Port en, input, 1 bit: scan enable.
REQ-007 Port lz_en, input, 1 bit: leading-zero blanking enable.
REQ-008 Port load, input, 1 bit: single-cycle request to stage digits_in.
REQ-009 Port digits_in, input, 16 bits: four BCD digits; [3:0] is digit 0 (least significant), [15:12] is digit 3.
REQ-010 Port load_ack, output, 1 bit: one-cycle pulse when staged digits become active.
REQ-011 Port digits_active, output, 16 bits: currently displayed digits; this port drives the digit mux data inputs (Dig1 = [3:0] … Dig4 = [15:12]).
REQ-012 Port sel, output, 2 bits: digit index; this port drives the digit mux select.
REQ-013 Port an, output, 4 bits: active-low anode enables, one-hot-low, where an[i] corresponds to sel == i.
REQ-014 Port frame_start, output, 1 bit: one-cycle pulse when sel wraps from 3 to 0.

Function
REQ-015 The prescaler SHALL count 0 to REFRESH_DIV-1 while en = 1 and SHALL hold while en = 0.
REQ-016 When the prescaler is at its terminal count (REFRESH_DIV-1) and en = 1, the prescaler SHALL return to 0 and sel SHALL advance 0→1→2→3→0 on the next edge.
REQ-017 The sel 3→0 transition SHALL be the frame boundary; frame_start SHALL be high for exactly the cycle in which sel first equals 0.
REQ-018 an SHALL be registered, and an SHALL be 4'b1111 when any of the following holds: the prescaler is below BLANK_CYCLES, en = 0, or the current digit is blanked.
REQ-019 Otherwise, an[sel] SHALL be 0 and all other an bits SHALL be 1; at most one an bit SHALL be low at any time.
REQ-020 Leading-zero blanking, when lz_en = 1, SHALL apply as follows: digit 3 is blanked if it equals 0; digit 2 is blanked if digits 3 and 2 both equal 0; digit 1 is blanked if digits 3..1 all equal 0; digit 0 is never blanked.
REQ-021 Blanking SHALL be evaluated on digits_active, not on digits_in.
REQ-022 When load = 1, digits_in SHALL be captured into a pending register and the pending flag SHALL be set.
REQ-023 A further load while the pending flag is set SHALL overwrite the pending register (last write wins), and only one load_ack SHALL be issued for the overwritten value.
REQ-024 At a frame boundary with the pending flag set, the pending register SHALL be copied to digits_active, the pending flag SHALL be cleared, and load_ack SHALL pulse in the same cycle as frame_start.
REQ-025 If load coincides with the frame-boundary edge, digits_in SHALL go directly to digits_active, the pending flag SHALL be cleared, and load_ack SHALL pulse.
REQ-026 digits_active SHALL never change except at a frame boundary, so a frame never mixes old and new digits.
REQ-027 While en = 0, loads SHALL still be staged, but no frame boundary and no load_ack SHALL occur.
REQ-028 Digit values 10–15 SHALL be passed through unmodified and SHALL count as non-zero for blanking.

Reset
REQ-029 Assertion of rst_n = 0 SHALL immediately force the following: prescaler = 0, sel = 2'b00, an = 4'b1111, digits_active = 16'h0000, pending flag = 0, load_ack = 0, frame_start = 0.
REQ-030 Reset asserted mid-slot or mid-load SHALL discard pending data.
REQ-031 After rst_n deasserts, scanning SHALL resume from slot 0 with a full guard interval.

Verification
REQ-032 The bench SHALL use REFRESH_DIV = 8 and BLANK_CYCLES = 2 for all of the following scenarios:
REQ-033 Scan: with en = 1 and digits_active = 16'h1234, sel SHALL step 0,1,2,3,0 every 8 cycles; each slot SHALL show an = 4'b1111 for 2 cycles, then 4'b1110 (sel 0) / 4'b1101 (sel 1) / 4'b1011 (sel 2) / 4'b0111 (sel 3) for 6 cycles; frame_start SHALL pulse once per 32 cycles.
REQ-034 Double buffer: load 16'h5678 in the middle of sel = 1 → digits_active SHALL remain 16'h1234 until the wrap, then change to 16'h5678 with load_ack and frame_start high in the same cycle.
REQ-035 Overwrite: load 16'hAAAA, then load 16'h0042 before the boundary → exactly one load_ack SHALL occur, and digits_active SHALL become 16'h0042.
REQ-036 Blanking: digits_active = 16'h0042 with lz_en = 1 → an SHALL stay 4'b1111 throughout the sel 3 and sel 2 slots, and slots 1 and 0 SHALL light normally; with lz_en = 0, all four slots SHALL light.
REQ-037 Enable/reset: en = 0 for 20 cycles → an SHALL be 4'b1111 and sel and the prescaler SHALL be frozen; a subsequent rst_n pulse mid-slot with a pending load → all outputs SHALL return to reset values, and no load_ack SHALL occur afterward.

Source files
------------

// File: rtl/display_scan_ctrl.sv
// Four-digit multiplexed display scanner: prescaled digit slots with a guard
// interval, frame-aligned double-buffered digit loads and leading-zero blanking.
module display_scan_ctrl #(
    parameter int REFRESH_DIV  = 100000,
    parameter int BLANK_CYCLES = 1000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        en,
    input  logic        lz_en,
    input  logic        load,
    input  logic [15:0] digits_in,
    output logic        load_ack,
    output logic [15:0] digits_active,
    output logic [1:0]  sel,
    output logic [3:0]  an,
    output logic        frame_start
);

    localparam int            CW      = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [CW-1:0] TERM    = CW'(REFRESH_DIV - 1);
    localparam logic [CW:0]   BLANK_W = (CW + 1)'(BLANK_CYCLES);

    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_nxt;
    logic [1:0]    sel_nxt;
    logic          slot_end;
    logic          wrap;
    logic          guard;
    logic [15:0]   act_nxt;
    logic [15:0]   pend_data;
    logic          pend;
    logic [3:0]    blank;
    logic [3:0]    an_nxt;

    // Outputs are registered from next-state values so that an, sel and the
    // displayed digits always describe the same slot in the same cycle.
    always_comb begin
        slot_end = en && (cnt == TERM);
        wrap     = slot_end && (sel == 2'd3);
        cnt_nxt  = cnt;
        sel_nxt  = sel;
        if (en) begin
            cnt_nxt = slot_end ? '0 : cnt + 1'b1;
        end
        if (slot_end) begin
            sel_nxt = sel + 2'd1;
        end

        act_nxt = digits_active;
        if (wrap) begin
            if (load) begin
                act_nxt = digits_in;
            end else if (pend) begin
                act_nxt = pend_data;
            end
        end

        blank[0] = 1'b0;
        blank[3] = lz_en && (act_nxt[15:12] == 4'd0);
        blank[2] = blank[3] && (act_nxt[11:8] == 4'd0);
        blank[1] = blank[2] && (act_nxt[7:4] == 4'd0);

        guard  = {1'b0, cnt_nxt} < BLANK_W;
        an_nxt = 4'b1111;
        if (en && !guard && !blank[sel_nxt]) begin
            an_nxt = ~(4'b0001 << sel_nxt);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt           <= '0;
            sel           <= 2'd0;
            an            <= 4'b1111;
            digits_active <= 16'h0000;
            pend_data     <= 16'h0000;
            pend          <= 1'b0;
            load_ack      <= 1'b0;
            frame_start   <= 1'b0;
        end else begin
            cnt           <= cnt_nxt;
            sel           <= sel_nxt;
            an            <= an_nxt;
            digits_active <= act_nxt;
            frame_start   <= wrap;
            load_ack      <= wrap && (load || pend);
            if (wrap) begin
                pend <= 1'b0;
            end else if (load) begin
                // Last write wins; a single ack covers every overwritten value.
                pend      <= 1'b1;
                pend_data <= digits_in;
            end
        end
    end

endmodule
